// File: rtl/neuron_ctrl_sync.sv
// neuron_ctrl_sync: sequencing controller for one spiking neuron.
// Arbitrates round-robin among N_IN four-phase synapse requests, steps the
// datapath through MUL -> ADD -> CMP stages of programmable length, forwards a
// four-phase request to the next neuron, and issues periodic leak strobes.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req_in/ack_in  per-channel four-phase handshake from the synapses
//   req_out/ack_out  four-phase handshake towards the next neuron
//   dly_mul/dly_add/dly_cmp  stage lengths in cycles (0 behaves as 1)
//   spike        comparator result from the datapath
//   sel          index of the granted channel
//   mul_en/acc_ld/cmp_en  datapath stage controls
//   pot_clr      potential clear after a fired spike is acknowledged
//   leak         one-cycle leak strobe
//   spike_out    latched spike flag, valid while req_out is high
// All outputs are registered.
module neuron_ctrl_sync #(
   parameter int unsigned N_IN        = 4,
   parameter int unsigned DELAY_W     = 4,
   parameter int unsigned FWD_ALL     = 0,
   parameter int unsigned LEAK_PERIOD = 16,
   localparam int unsigned SelW       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_IN-1:0]    req_in,
   output logic [N_IN-1:0]    ack_in,
   output logic               req_out,
   input  logic               ack_out,
   input  logic [DELAY_W-1:0] dly_mul,
   input  logic [DELAY_W-1:0] dly_add,
   input  logic [DELAY_W-1:0] dly_cmp,
   input  logic               spike,
   output logic [SelW-1:0]    sel,
   output logic               mul_en,
   output logic               acc_ld,
   output logic               cmp_en,
   output logic               pot_clr,
   output logic               leak,
   output logic               spike_out
);

   localparam int unsigned LeakW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

   typedef enum logic [2:0] {
      StIdle, StMul, StAdd, StCmp, StFireH, StFireL, StAck
   } state_e;

   state_e             state_q, state_d;
   logic [DELAY_W-1:0] cnt_q, cnt_d;
   logic [SelW-1:0]    sel_q, sel_d;
   logic [SelW-1:0]    ptr_q, ptr_d;
   logic               spike_q, spike_d;
   logic [LeakW-1:0]   leak_cnt_q, leak_cnt_d;
   logic               leak_pend_q, leak_pend_d;
   logic               leak_expire, leak_d, pot_d;

   logic [N_IN-1:0]    ack_in_q;
   logic               req_out_q, mul_en_q, acc_ld_q, cmp_en_q, pot_clr_q, leak_q, spike_out_q;

   logic [N_IN-1:0]    req_rot;
   logic               found;
   logic [SelW-1:0]    pick;

   function automatic logic [DELAY_W-1:0] eff_dly(input logic [DELAY_W-1:0] d);
      return (d == '0) ? DELAY_W'(1) : d;
   endfunction

   // Rotate requests so bit 0 is the channel at ptr, then take the first set bit.
   always_comb begin
      found   = 1'b0;
      pick    = '0;
      req_rot = N_IN'({req_in, req_in} >> ptr_q);
      for (int i = 0; i < N_IN; i++) begin
         if (!found && req_rot[i]) begin
            found = 1'b1;
            pick  = SelW'((int'(ptr_q) + i) % int'(N_IN));
         end
      end
   end

   // Free-running leak counter; pending flag holds expiries until the next idle cycle.
   always_comb begin
      leak_expire = (LEAK_PERIOD != 0) && (leak_cnt_q == LeakW'(LEAK_PERIOD - 1));
      if (LEAK_PERIOD == 0 || leak_expire) begin
         leak_cnt_d = '0;
      end else begin
         leak_cnt_d = leak_cnt_q + 1'b1;
      end
      // Never two strobes back to back, so a grant always gets a chance in between.
      leak_d      = (LEAK_PERIOD != 0) && (state_d == StIdle) && !leak_q &&
                    (leak_pend_q || leak_expire);
      leak_pend_d = (leak_pend_q || leak_expire) && !leak_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      spike_d = spike_q;
      pot_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A cycle carrying the leak strobe defers any grant by one cycle.
            if (!leak_q && found) begin
               sel_d   = pick;
               cnt_d   = eff_dly(dly_mul);
               state_d = StMul;
            end
         end
         StMul: begin
            if (cnt_q <= DELAY_W'(1)) begin
               cnt_d   = eff_dly(dly_add);
               state_d = StAdd;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StAdd: begin
            if (cnt_q <= DELAY_W'(1)) begin
               cnt_d   = eff_dly(dly_cmp);
               state_d = StCmp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StCmp: begin
            if (cnt_q <= DELAY_W'(1)) begin
               spike_d = spike;
               state_d = (spike || FWD_ALL != 0) ? StFireH : StAck;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StFireH: begin
            if (ack_out) begin
               pot_d   = spike_q;
               state_d = StFireL;
            end
         end
         StFireL: begin
            if (!ack_out) state_d = StAck;
         end
         StAck: begin
            if (!req_in[sel_q]) begin
               ptr_d   = (sel_q == SelW'(N_IN - 1)) ? '0 : sel_q + 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sel_q       <= '0;
         ptr_q       <= '0;
         spike_q     <= 1'b0;
         leak_cnt_q  <= '0;
         leak_pend_q <= 1'b0;
         ack_in_q    <= '0;
         req_out_q   <= 1'b0;
         mul_en_q    <= 1'b0;
         acc_ld_q    <= 1'b0;
         cmp_en_q    <= 1'b0;
         pot_clr_q   <= 1'b0;
         leak_q      <= 1'b0;
         spike_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         spike_q     <= spike_d;
         leak_cnt_q  <= leak_cnt_d;
         leak_pend_q <= leak_pend_d;
         // Outputs are decoded from the next state so they line up with it.
         ack_in_q    <= (state_d == StAck) ? (N_IN'(1) << sel_d) : '0;
         req_out_q   <= (state_d == StFireH);
         mul_en_q    <= (state_d == StMul);
         acc_ld_q    <= (state_d == StAdd) && (cnt_d == DELAY_W'(1));
         cmp_en_q    <= (state_d == StCmp);
         pot_clr_q   <= pot_d;
         leak_q      <= leak_d;
         spike_out_q <= (state_d == StFireH) && spike_d;
      end
   end

   assign ack_in    = ack_in_q;
   assign req_out   = req_out_q;
   assign sel       = sel_q;
   assign mul_en    = mul_en_q;
   assign acc_ld    = acc_ld_q;
   assign cmp_en    = cmp_en_q;
   assign pot_clr   = pot_clr_q;
   assign leak      = leak_q;
   assign spike_out = spike_out_q;

   // ack_out already high when the forward request is raised breaks the handshake.
   a_ack_out_early : assert property (@(posedge clk) disable iff (!rst)
      (state_q != StFireH && state_d == StFireH) |-> !ack_out);

   a_stage_onehot : assert property (@(posedge clk) disable iff (!rst)
      $onehot0({mul_en_q, acc_ld_q, cmp_en_q}));

endmodule
